// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the start/rw/done request protocol: FSM state
// encoding, rw polarity and a counter sizing helper.
package ram_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Width needed to count 0..lat-1, never less than one bit.
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat > 1) ? $clog2(lat) : 1;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Single-port storage array: synchronous write, combinational read, no reset.
module ram_array #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ram_responder.sv
// Memory-side responder: four-phase start/done handshake, ACCESS_LAT wait
// states, range-checked write/read of a wrapped single-port array.
module ram_responder
  import ram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256,
  parameter int ACCESS_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rw,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  done,
  output logic                  busy,
  output logic                  err
);

  localparam int CNT_W = cnt_width(ACCESS_LAT);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_LAT - 1);
  // One extra bit so DEPTH == 2**ADDR_WIDTH is representable and never flags.
  localparam logic [ADDR_WIDTH:0] DEPTH_EXT = (ADDR_WIDTH + 1)'(DEPTH);

  state_t                  state;
  logic                    req_rw;
  logic [ADDR_WIDTH-1:0]   req_address;
  logic [DATA_WIDTH-1:0]   req_write_data;
  logic [CNT_W-1:0]        cnt;
  logic                    in_range;
  logic                    array_we;
  logic [DATA_WIDTH-1:0]   array_rdata;

  assign in_range = ({1'b0, req_address} < DEPTH_EXT);

  // Commit happens only on the first ACCESS edge, so a reset before it aborts the write.
  assign array_we = (state == ST_ACCESS) && (cnt == '0) &&
                    (req_rw == RW_WRITE) && in_range;

  assign busy = (state != ST_IDLE);

  ram_array #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (clk),
    .we   (array_we),
    .waddr(req_address),
    .wdata(req_write_data),
    .raddr(req_address),
    .rdata(array_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      req_rw         <= RW_READ;
      req_address    <= '0;
      req_write_data <= '0;
      cnt            <= '0;
      read_data      <= '0;
      done           <= 1'b0;
      err            <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            req_rw         <= rw;
            req_address    <= address;
            req_write_data <= write_data;
            cnt            <= '0;
            state          <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST_CNT) begin
            state <= ST_RESP;
            done  <= 1'b1;
            err   <= !in_range;
            if (req_rw == RW_READ) begin
              read_data <= in_range ? array_rdata : '0;
            end
          end
        end
        ST_RESP: begin
          // A held start keeps us here; only a released start frees the responder.
          if (!start) begin
            state <= ST_IDLE;
            done  <= 1'b0;
            err   <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_responder.sv
// Self-checking bench for ram_responder: four instances (default, DEPTH=200,
// ACCESS_LAT=1, ACCESS_LAT=4) driven by directed steps with a scoreboard.
module tb_ram_responder;

  localparam int NI = 4;
  localparam int DEPTHS [NI] = '{256, 200, 256, 256};
  localparam int LATS   [NI] = '{2, 2, 1, 4};
  localparam int WAIT_BOUND = 20;

  typedef struct {
    int         idx;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       start      [NI];
  logic       rw         [NI];
  logic [7:0] address    [NI];
  logic [7:0] write_data [NI];
  logic [7:0] read_data  [NI];
  logic       done       [NI];
  logic       busy       [NI];
  logic       err        [NI];

  int         checks;
  int         errors;
  exp_t       sb [$];
  logic [7:0] model   [NI][256];
  logic [7:0] last_rd [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    ram_responder #(
      .ADDR_WIDTH(8),
      .DATA_WIDTH(8),
      .DEPTH     (DEPTHS[g]),
      .ACCESS_LAT(LATS[g])
    ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .rw        (rw[g]),
      .address   (address[g]),
      .write_data(write_data[g]),
      .read_data (read_data[g]),
      .done      (done[g]),
      .busy      (busy[g]),
      .err       (err[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int i,
                             input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s inst%0d: observed %0h expected %0h", tag, i, observed, expected);
    end
  endtask

  // Issues one request, checks latency/busy, pops the scoreboard at done,
  // optionally holds start with junk inputs, then releases and checks exit.
  task automatic applyStimulus(input int i, input logic w, input logic [7:0] a,
                               input logic [7:0] d, input int hold, input bit drop_early);
    exp_t e;
    exp_t got;
    int   lat;
    logic ok;
    ok     = ({1'b0, a} < 9'(DEPTHS[i]));
    e.idx  = i;
    e.err  = !ok;
    e.data = w ? last_rd[i] : (ok ? model[i][a] : 8'h00);
    if (w && ok) model[i][a] = d;
    last_rd[i] = e.data;
    sb.push_back(e);

    @(negedge clk);
    start[i] = 1'b1; rw[i] = w; address[i] = a; write_data[i] = d;
    @(posedge clk); #1;
    checkOutput("busy_capture", i, 32'(busy[i]), 32'd1);
    if (drop_early) begin
      @(negedge clk);
      start[i] = 1'b0; rw[i] = 1'b0; address[i] = 8'h00;
    end
    lat = 0;
    while (lat < WAIT_BOUND) begin
      @(posedge clk); #1;
      lat++;
      if (done[i] === 1'b1) break;
      checkOutput("busy_access", i, 32'(busy[i]), 32'd1);
    end
    checkOutput("latency", i, 32'(lat), 32'(LATS[i]));
    checkOutput("done_set", i, 32'(done[i]), 32'd1);
    got = sb.pop_front();
    checkOutput("read_data", i, 32'(read_data[i]), 32'(got.data));
    checkOutput("err", i, 32'(err[i]), 32'(got.err));

    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      rw[i] = 1'b1; address[i] = 8'h10 + 8'(k % 2); write_data[i] = 8'hEE;
      @(posedge clk); #1;
      checkOutput("hold_done", i, 32'(done[i]), 32'd1);
      checkOutput("hold_data", i, 32'(read_data[i]), 32'(got.data));
    end

    if (!drop_early) begin
      @(negedge clk);
      start[i] = 1'b0; rw[i] = 1'b0;
    end
    @(posedge clk); #1;
    checkOutput("exit_done", i, 32'(done[i]), 32'd0);
    checkOutput("exit_busy", i, 32'(busy[i]), 32'd0);
    checkOutput("exit_err", i, 32'(err[i]), 32'd0);
    checkOutput("exit_data", i, 32'(read_data[i]), 32'(got.data));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    for (int i = 0; i < NI; i++) begin
      start[i] = 1'b0; rw[i] = 1'b0; address[i] = 8'h00; write_data[i] = 8'h00;
      last_rd[i] = 8'h00;
    end
    #12;
    for (int i = 0; i < NI; i++) begin
      checkOutput("rst_done", i, 32'(done[i]), 32'd0);
      checkOutput("rst_busy", i, 32'(busy[i]), 32'd0);
      checkOutput("rst_err", i, 32'(err[i]), 32'd0);
      checkOutput("rst_data", i, 32'(read_data[i]), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read, no aliasing, held start.
    applyStimulus(0, 1'b1, 8'h10, 8'hAB, 0, 1'b0);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    applyStimulus(0, 1'b1, 8'h20, 8'hCD, 0, 1'b0);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, 0, 1'b0);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    applyStimulus(0, 1'b0, 8'h20, 8'h00, 10, 1'b0);
    applyStimulus(0, 1'b0, 8'h10, 8'h00, 0, 1'b0);
    applyStimulus(0, 1'b0, 8'h11, 8'h00, 0, 1'b0);

    // DEPTH=200 range checks.
    applyStimulus(1, 1'b1, 8'hF0, 8'h5A, 0, 1'b0);
    applyStimulus(1, 1'b0, 8'hF0, 8'h00, 0, 1'b0);
    applyStimulus(1, 1'b1, 8'hC7, 8'h77, 0, 1'b0);
    applyStimulus(1, 1'b0, 8'hC7, 8'h00, 0, 1'b0);
    applyStimulus(1, 1'b0, 8'hC8, 8'h00, 0, 1'b0);

    // Latency 1 and 4, including start dropped during ACCESS.
    applyStimulus(2, 1'b1, 8'h05, 8'h42, 0, 1'b0);
    applyStimulus(2, 1'b0, 8'h05, 8'h00, 0, 1'b0);
    applyStimulus(2, 1'b0, 8'h05, 8'h00, 0, 1'b1);
    applyStimulus(3, 1'b1, 8'h06, 8'h24, 0, 1'b0);
    applyStimulus(3, 1'b0, 8'h06, 8'h00, 0, 1'b1);
    applyStimulus(3, 1'b1, 8'h07, 8'h3E, 0, 1'b1);
    applyStimulus(3, 1'b0, 8'h07, 8'h00, 0, 1'b0);

    // Reset during the first ACCESS cycle of a write must not commit it.
    applyStimulus(0, 1'b1, 8'h30, 8'h11, 0, 1'b0);
    @(negedge clk);
    start[0] = 1'b1; rw[0] = 1'b1; address[0] = 8'h30; write_data[0] = 8'h99;
    @(posedge clk); #1;
    checkOutput("pre_rst_busy", 0, 32'(busy[0]), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", 0, 32'(busy[0]), 32'd0);
    checkOutput("mid_rst_done", 0, 32'(done[0]), 32'd0);
    checkOutput("mid_rst_err", 0, 32'(err[0]), 32'd0);
    checkOutput("mid_rst_data", 0, 32'(read_data[0]), 32'd0);
    @(negedge clk);
    start[0] = 1'b0; rw[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < NI; i++) last_rd[i] = 8'h00;
    applyStimulus(0, 1'b0, 8'h30, 8'h00, 0, 1'b0);
    applyStimulus(1, 1'b0, 8'hC7, 8'h00, 0, 1'b0);

    checkOutput("sb_empty", 0, 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
